// File: rtl/z16_fetch_pkg.sv
// z16_fetch_pkg
// Shared types and constants for the z16 instruction fetch queue.
//   Z16_INSTR_W   : instruction word width
//   Z16_PC_STEP   : byte increment between sequential fetches
//   fetch_entry_t : one queued instruction together with its fetch address
package z16_fetch_pkg;

    localparam int Z16_INSTR_W = 16;
    localparam int Z16_PC_STEP = 2;

    typedef struct packed {
        logic [15:0]            pc;
        logic [Z16_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/z16_fetch_fifo.sv
// z16_fetch_fifo
// Circular buffer of DEPTH fetch entries with flush.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_flush       : drop every entry; wins over a push in the same cycle
//   i_push        : write i_push_data at the tail
//   i_pop         : retire the head (ignored when empty)
//   o_head        : head entry (undefined content when o_count == 0)
//   o_count       : number of valid entries, 0..DEPTH
module z16_fetch_fifo
    import z16_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  fetch_entry_t     i_push_data,
    input  logic             i_pop,
    output fetch_entry_t     o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_pop   = i_pop && (count_q != '0);
        // A push into a full buffer is only legal when the head leaves this cycle.
        do_push  = i_push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = i_push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/z16_fetch_queue.sv
// z16_fetch_queue
// Sequential instruction fetcher feeding a small FIFO in front of the decoder.
// One memory read may be issued per cycle; data returns one cycle later and
// is queued with its address. A redirect flushes the queue and restarts fetch.
// Optional feature macro: Z16_FETCH_PERF_EN adds o_fetch_count, a wrapping
// count of completed decoder transfers, cleared by reset only.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   o_imem_req/o_imem_addr : memory read request and byte address
//   i_imem_rdata           : read data, one cycle after the request
//   i_redirect/_pc         : flush and restart fetch at i_redirect_pc
//   o_instr_valid/_instr/_pc, i_instr_ready : decoder handshake on queue head
//   o_fetch_count          : transfer counter (only with Z16_FETCH_PERF_EN)
module z16_fetch_queue
    import z16_fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [15:0] o_imem_addr,
    input  logic [15:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    output logic        o_instr_valid,
    output logic [15:0] o_instr,
    output logic [15:0] o_instr_pc,
    input  logic        i_instr_ready
`ifdef Z16_FETCH_PERF_EN
    ,
    output logic [15:0] o_fetch_count
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [15:0]      pc_q, pc_d;
    logic [15:0]      req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     head;
    fetch_entry_t     push_data;
    logic             head_valid;
    logic             pop;
    logic             req;
    logic [5:0]       occupancy;

    // Request only if the entry it will produce has a guaranteed slot,
    // counting the in-flight response and crediting a pop this cycle.
    always_comb begin
        head_valid = !i_rst && (fifo_count != '0);
        pop        = head_valid && i_instr_ready;
        occupancy  = 6'(fifo_count) + 6'(inflight_q) - 6'(pop);
        req        = !i_rst && !i_redirect && (occupancy < 6'(DEPTH));
    end

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = req;
        if (i_redirect) begin
            pc_d = i_redirect_pc;
        end else if (req) begin
            pc_d     = pc_q + 16'(Z16_PC_STEP);
            req_pc_d = pc_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    assign push_data.pc    = req_pc_q;
    assign push_data.instr = i_imem_rdata;

    // A response landing in the redirect cycle belongs to the old stream;
    // the FIFO flush discards it along with the stored entries.
    z16_fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (i_redirect),
        .i_push      (inflight_q),
        .i_push_data (push_data),
        .i_pop       (pop),
        .o_head      (head),
        .o_count     (fifo_count)
    );

    // pc_q may still hold a pre-reset value during the first reset cycle.
    assign o_imem_req    = req;
    assign o_imem_addr   = i_rst ? RESET_PC : pc_q;
    assign o_instr_valid = head_valid;
    assign o_instr       = head_valid ? head.instr : '0;
    assign o_instr_pc    = head_valid ? head.pc : '0;

`ifdef Z16_FETCH_PERF_EN
    logic [15:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (pop) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign o_fetch_count = fetch_count_q;
`endif

endmodule

// File: doc/z16_fetch_queue.md
Z16_FETCH_QUEUE -- requirements
Module: z16_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the number of queue entries; legal range is 2..16.
REQ-002 Parameter RESET_PC, default 16'h0000, SHALL set the first fetch address after reset.
REQ-003 Port i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port i_rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Port o_imem_req  output  1  SHALL signal an instruction-memory read this cycle; the memory always accepts.
REQ-006 Port o_imem_addr  output  16  SHALL carry the byte address of that read.
REQ-007 Port i_imem_rdata  input  16  SHALL carry read data exactly one cycle after the request.
REQ-008 Port i_redirect  input  1  SHALL request a flush and a restart of fetch.
REQ-009 Port i_redirect_pc  input  16  SHALL carry the restart address; it is sampled only when i_redirect=1.
REQ-010 Port o_instr_valid  output  1  SHALL indicate that the queue head is valid for the decoder.
REQ-011 Port o_instr  output  16  SHALL carry the head instruction word.
REQ-012 Port o_instr_pc  output  16  SHALL carry the head instruction's address.
REQ-013 Port i_instr_ready  input  1  SHALL indicate that the decoder accepts the head; a transfer occurs when valid and ready are both 1.

Function
REQ-014 Request condition: o_imem_req=1 iff !i_rst && !i_redirect && (count + inflight - pop) < DEPTH, where pop = o_instr_valid & i_instr_ready.
REQ-015 Fetch PC: on each request, the fetch PC SHALL advance by 2 modulo 2^16 (16'hFFFE -> 16'h0000).
REQ-016 Capture: the queue SHALL capture the response in the cycle after a non-flushed request, together with that request's address, into the tail.
REQ-017 Latency: for a request in cycle N, o_instr_valid SHALL rise in cycle N+2 when the queue was empty.
REQ-018 Throughput: with i_instr_ready held at 1, the queue SHALL sustain one transfer per cycle.
REQ-019 Ordering: entries SHALL leave in FIFO order, never duplicated and never dropped except by flush.
REQ-020 Simultaneous capture and pop on a full queue SHALL be legal, and the count SHALL be unchanged.
REQ-021 Redirect in cycle R:
  - a transfer in R still completes;
  - all remaining entries and any response arriving in R+1 SHALL be discarded;
  - fetch PC SHALL become i_redirect_pc;
  - the first new request SHALL occur in R+1.
REQ-022 Back-to-back redirects: the last one SHALL win, and no request SHALL issue while i_redirect=1.
REQ-023 When o_instr_valid=1 and i_instr_ready=0, o_instr and o_instr_pc SHALL hold stable.

Reset
REQ-024 While i_rst=1:
  - o_imem_req=0, o_imem_addr=RESET_PC;
  - o_instr_valid=0, o_instr=0, o_instr_pc=0;
  - the queue is empty, the in-flight flag is 0, and fetch PC=RESET_PC.
REQ-025 Reset mid-operation SHALL discard all entries and any in-flight response.
REQ-026 The first request SHALL occur in the first cycle with i_rst=0.

Configuration
REQ-027 With macro Z16_FETCH_PERF_EN defined, the block SHALL add output o_fetch_count (16 bits):
  - it counts completed transfers and wraps at 16'hFFFF;
  - it is cleared by reset only.
REQ-028 Without Z16_FETCH_PERF_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package z16_fetch_pkg SHALL hold:
  - constants Z16_INSTR_W=16 and Z16_PC_STEP=2;
  - typedef fetch_entry_t {pc[15:0], instr[15:0]}.
REQ-030 Storage SHALL be one sub-module, z16_fetch_fifo (DEPTH entries of fetch_entry_t, push/pop/flush, count output).
REQ-031 PC logic, request logic and the in-flight flag SHALL live in z16_fetch_queue.

Verification
REQ-032 Reset release, ready=1, memory returns addr^16'hA5A5:
  - requests at 0000, 0002, 0004...;
  - first valid two cycles later with pc=0000, instr=A5A5;
  - one transfer per cycle thereafter.
REQ-033 Ready=0 for 6 cycles after start:
  - requests stop once DEPTH entries are filled or in flight;
  - the head holds pc=0000;
  - on ready=1, pcs 0000, 0002... drain in order with no gap or duplicate.
REQ-034 Redirect to 16'h0100 while the queue is full and a request is in flight:
  - no stale entry appears;
  - next valid has pc=0100 exactly 3 cycles after the redirect.
REQ-035 RESET_PC=16'hFFFC with ready=1: fetched pcs are FFFC, FFFE, 0000, 0002.
REQ-036 Reset asserted for 1 cycle while the queue holds 2 entries:
  - valid=0 the next cycle;
  - refetch starts at RESET_PC;
  - with Z16_FETCH_PERF_EN defined, o_fetch_count=0 after reset and equals the number of transfers completed since.
